// File: rtl/sw_digit_capture.sv
// sw_digit_capture: switch input stage for the password lock.
// Two-flop synchronises the raw switches, debounces each bit with its own counter, and then
// turns each isolated activation into a one-cycle digit event. Two or more switches that
// become active together produce a multi_err pulse instead of a digit event.
// Optional build macro SW_DEBOUNCE_BYPASS_EN removes the counters, so sw_clean follows the
// synchronised level on every edge (for fast simulation).
module sw_digit_capture #(
  parameter int unsigned N_SW            = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_clean,
  output logic [3:0]      digit,
  output logic            digit_valid,
  output logic            multi_err,
  output logic            busy
);

  typedef enum logic {
    StIdle,
    StHeld
  } state_t;

  logic [N_SW-1:0] s1_q, s2_q;
  state_t          state_q, state_d;
  logic [3:0]      digit_d;
  logic            digit_valid_d, multi_err_d;
  logic [4:0]      ones;
  logic [3:0]      idx;

  // Two-flop synchroniser for the asynchronous switch levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw;
      s2_q <= s1_q;
    end
  end

`ifdef SW_DEBOUNCE_BYPASS_EN
  // Bypass build: clean level is simply the synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sw_clean <= '0;
    else     sw_clean <= s2_q;
  end
`else
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [N_SW];

  // Per-bit debounce: a new level is accepted only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_clean <= '0;
      for (int i = 0; i < int'(N_SW); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_SW); i++) begin
        if (s2_q[i] != sw_clean[i]) begin
          if (cnt_q[i] == CntMax) begin
            sw_clean[i] <= s2_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          // Any sample matching the clean level restarts the count
          cnt_q[i] <= '0;
        end
      end
    end
  end
`endif

  // Count active clean switches and find the index of the (highest) active one
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      if (sw_clean[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
  end

  // Event FSM next state: one event per activation, nothing until full release
  always_comb begin
    state_d       = state_q;
    digit_d       = digit;
    digit_valid_d = 1'b0;
    multi_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ones == 5'd1) begin
          digit_d       = idx;
          digit_valid_d = 1'b1;
          state_d       = StHeld;
        end else if (ones > 5'd1) begin
          multi_err_d = 1'b1;
          state_d     = StHeld;
        end
      end
      StHeld: begin
        if (ones == 5'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered event outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      digit       <= '0;
      digit_valid <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit       <= digit_d;
      digit_valid <= digit_valid_d;
      multi_err   <= multi_err_d;
    end
  end

  assign busy = (state_q == StHeld);

endmodule

// File: tb/tb_sw_digit_capture.sv
// Scoreboard bench for sw_digit_capture with DEBOUNCE_CYCLES=4.
// Stimulus pushes expected events into a queue; a monitor pops and compares whenever the
// DUT pulses digit_valid or multi_err. Inputs change on the falling edge, so the first
// rising edge after a change is edge 0; a check after cycles(k+1) observes state after edge k.
module tb_sw_digit_capture;

  localparam int unsigned NSw = 10;

  typedef struct {
    bit         is_err;
    logic [3:0] digit;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NSw-1:0] sw  = '0;
  logic [NSw-1:0] sw_clean;
  logic [3:0]     digit;
  logic           digit_valid, multi_err, busy;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  sw_digit_capture #(
    .N_SW           (NSw),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .sw_clean   (sw_clean),
    .digit      (digit),
    .digit_valid(digit_valid),
    .multi_err  (multi_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_digit(input logic [3:0] d);
    ev_t e;
    e.is_err = 1'b0;
    e.digit  = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.digit  = '0;
    exp_q.push_back(e);
  endtask

  // Press one switch, hold, then fully release
  task automatic press(input int idx);
    push_digit(4'(idx));
    sw = NSw'(1) << idx;
    cycles(10);
    chk("press_busy", 32'(busy), 1);
    chk("press_clean", 32'(sw_clean), 32'(NSw'(1) << idx));
    sw = '0;
    cycles(10);
    chk("release_busy", 32'(busy), 0);
  endtask

  // Monitor: compare every event pulse against the scoreboard
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("event_exclusive", 32'(digit_valid & multi_err), 0);
        if (digit_valid || multi_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", {30'd0, multi_err, digit_valid}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(multi_err), 32'(e.is_err));
            if (!e.is_err) chk("event_digit", 32'(digit), 32'(e.digit));
          end
        end
      end
    end
  end

  initial begin
    // Reset with every switch high
    sw  = 10'h3FF;
    rst = 1'b1;
    cycles(3);
    chk("rst_clean", 32'(sw_clean), 0);
    chk("rst_digit", 32'(digit), 0);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_err", 32'(multi_err), 0);
    chk("rst_busy", 32'(busy), 0);
    push_err();
    rst = 1'b0;
    cycles(6);
    chk("rst_clean_e5", 32'(sw_clean), 32'h3FF);
    chk("rst_busy_e5", 32'(busy), 0);
    cycles(1);
    chk("rst_err_e6", 32'(multi_err), 1);
    chk("rst_busy_e6", 32'(busy), 1);
    cycles(1);
    chk("rst_err_e7", 32'(multi_err), 0);
    sw = '0;
    cycles(10);
    chk("rst_release_busy", 32'(busy), 0);

    // Clean press of switch 2 with exact latency
    push_digit(4'd2);
    sw = 10'b0000000100;
    cycles(5);
    chk("press_clean_e4", 32'(sw_clean), 0);
    cycles(1);
    chk("press_clean_e5", 32'(sw_clean), 32'h004);
    chk("press_valid_e5", 32'(digit_valid), 0);
    cycles(1);
    chk("press_valid_e6", 32'(digit_valid), 1);
    chk("press_digit_e6", 32'(digit), 2);
    chk("press_busy_e6", 32'(busy), 1);
    cycles(1);
    chk("press_valid_e7", 32'(digit_valid), 0);
    chk("press_digit_hold", 32'(digit), 2);
    cycles(3);
    sw = '0;
    cycles(6);
    chk("release_busy_e5", 32'(busy), 1);
    cycles(1);
    chk("release_busy_e6", 32'(busy), 0);
    cycles(4);

    // Glitch shorter than the debounce window is rejected
    sw = 10'b0000000010;
    cycles(3);
    sw = '0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk("glitch_clean", 32'(sw_clean), 0);
    end

    // Counter must have restarted: a real press still takes the full latency
    push_digit(4'd1);
    sw = 10'b0000000010;
    cycles(5);
    chk("post_glitch_e4", 32'(sw_clean), 0);
    cycles(1);
    chk("post_glitch_e5", 32'(sw_clean), 32'h002);
    cycles(5);
    sw = '0;
    cycles(10);

    // Sequence 2,0,1,6
    press(2);
    press(0);
    press(1);
    press(6);

    // Held switch 0, then add switch 7: only one event
    push_digit(4'd0);
    sw = 10'b0000000001;
    cycles(10);
    sw = sw | 10'b0010000000;
    cycles(10);
    chk("hold_clean", 32'(sw_clean), 32'h081);
    chk("hold_busy", 32'(busy), 1);
    chk("hold_digit", 32'(digit), 0);
    sw = '0;
    cycles(10);
    chk("hold_release_busy", 32'(busy), 0);

    // Switches 5 and 8 together: multi_err, digit unchanged
    push_err();
    sw = 10'b0100100000;
    cycles(10);
    chk("multi_digit", 32'(digit), 0);
    chk("multi_busy", 32'(busy), 1);
    sw = '0;
    cycles(10);

    // Reset two cycles into a debounce count: no event, full re-debounce afterwards
    sw = 10'b0000000100;
    cycles(4);
    rst = 1'b1;
    cycles(2);
    chk("midrst_clean", 32'(sw_clean), 0);
    chk("midrst_busy", 32'(busy), 0);
    push_digit(4'd2);
    rst = 1'b0;
    cycles(5);
    chk("midrst_clean_e4", 32'(sw_clean), 0);
    cycles(1);
    chk("midrst_clean_e5", 32'(sw_clean), 32'h004);
    cycles(1);
    chk("midrst_valid_e6", 32'(digit_valid), 1);
    chk("midrst_digit_e6", 32'(digit), 2);
    cycles(3);
    sw = '0;
    cycles(10);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_digit_capture.md
Name: sw_digit_capture

Overview:
- Input stage of the password lock. Sits between the raw board switches and the password FSM.
- Synchronises and debounces the 10 slide switches, then turns each clean, isolated switch activation into a one-cycle digit event (index 0–9) for the FSM.
- Rejects simultaneous multi-switch activations with an error pulse.
- Also exports the clean switch vector for display and debug.

Parameters:
- N_SW, 10, number of switch inputs (max 16).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level (1 ms at 50 MHz); must be ≥1.
- CNT_W, 16, width of the per-switch debounce counters; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- sw  input  N_SW  raw switch levels, asynchronous to clk.
- sw_clean  output  N_SW  debounced switch levels.
- digit  output  4  index of the last accepted switch; held between events.
- digit_valid  output  1  one-cycle pulse; digit is new this cycle.
- multi_err  output  1  one-cycle pulse; more than one switch became active together.
- busy  output  1  high while any clean switch is high (FSM in HELD).

Behaviour:
- Reset (async, active-high) forces all outputs to 0: sw_clean, digit, digit_valid, multi_err, busy. Reset also clears both synchroniser stages, all counters, and the FSM state (IDLE). Asserting reset mid-hold drops any pending event.
- Synchroniser: 2-FF per bit, s1 <= sw, s2 <= s1.
- Debounce, per bit, per clock edge:
  - if s2 != sw_clean[i]: if cnt[i] == DEBOUNCE_CYCLES-1 then sw_clean[i] <= s2 and cnt[i] <= 0, else cnt[i] <= cnt[i]+1.
  - if s2 == sw_clean[i]: cnt[i] <= 0. Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Latency: call edge 0 the first edge that samples the new sw level.
  - sw_clean updates at edge DEBOUNCE_CYCLES+1.
  - digit_valid is high in the cycle after edge DEBOUNCE_CYCLES+2.
- FSM with two states:
  - IDLE, entered when sw_clean == 0.
    - If sw_clean has exactly one bit set: digit <= that index, digit_valid pulses for 1 cycle, go to HELD.
    - If sw_clean has ≥2 bits set: multi_err pulses for 1 cycle, digit unchanged, go to HELD.
  - HELD: remain until sw_clean == 0, then go to IDLE. No events are generated in HELD; extra switches raised here are ignored, whether added or removed.
- busy is high exactly while the state is HELD.
- Switch high at reset release: the bit is debounced like any other rise and produces an event once clean. This is intentional, and the FSM downstream tolerates it.
- Releasing a switch and re-raising it produces a new event only after sw_clean returns to all-zero (full release).
- digit_valid and multi_err are never high in the same cycle.
- digit_valid and multi_err are registered outputs; there is no combinational path from sw.

Optional Feature:
- Macro: SW_DEBOUNCE_BYPASS_EN.
- Defined: counters are removed, sw_clean <= s2 every edge, and digit_valid appears after edge 3. Used for fast simulation and for benches that previously stubbed out the debouncer.
- Undefined (default): full counter debounce as specified above.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset: hold rst high with sw=10'h3FF -> all outputs 0. After release, the 3FF level yields exactly one multi_err pulse, then busy=1 until sw returns to 0.
- Clean press: sw=10'b0000000100 held 10 cycles from edge 0 -> sw_clean[2] rises at edge 5, digit=2, digit_valid high after edge 6 for exactly 1 cycle, busy=1. sw=0 -> busy falls 6 edges later.
- Glitch reject: sw[1] high for 3 cycles, then low -> sw_clean stays 0, no digit_valid, counter returns to 0.
- Sequence 2,0,1,6 with full release between presses -> four digit_valid pulses carrying digit 2,0,1,6 in order.
- Multi/hold: sw=10'b0000000001 held, then sw[7] added -> single digit_valid with digit=0, no event for 7. Releasing both then raising sw[5]|sw[8] together -> multi_err pulse, digit stays 0.
- Reset mid-operation: rst asserted 2 cycles into a debounce count -> no event; after release the still-held switch is re-debounced from 0 (DEBOUNCE_CYCLES+2 edges).
